debug_mem_dump: RTL and testbench

Read-side companion to the data memory debug port: on command it walks `debug_addr` across every data-memory word and reads each `debug_data` word. It then serialises each word as four little-endian bytes on a UART 8N1 transmitter. The block sits beside the datapath at top level. It lets the FPGA board stream the data-memory contents to a host without halting the core or touching the load/store path.

---
 rtl/debug_pkg.sv | 24 ++
 rtl/debug_mem_dump_if.sv | 13 +
 rtl/uart_tx_byte.sv | 68 ++++++
 rtl/debug_mem_dump.sv | 98 +++++++++
 tb/tb_debug_mem_dump.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_pkg.sv
// Shared types and constants for the data-memory dump block.
package debug_pkg;

   // Top-level sequencing states, exposed on dbg_state for observation.
   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CAPTURE,
      START,
      DATA,
      STOP,
      NEXT
   } state_t;

   localparam logic UART_IDLE      = 1'b1;
   localparam logic UART_START     = 1'b0;
   localparam int   BYTES_PER_WORD = 4;

   // Little-endian byte select: idx 0 is bits [7:0], idx 3 is bits [31:24].
   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
      return w[{idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/debug_mem_dump_if.sv
// Data-memory debug read port: the dump block drives the word index, the
// memory returns the registered read data one cycle later.
interface debug_mem_dump_if #(
   parameter int ADDR_W = 8
) ();

   logic [ADDR_W-1:0] debug_addr;
   logic [31:0]       debug_data;

   modport master (output debug_addr, input debug_data);
   modport slave  (input debug_addr, output debug_data);

endinterface

// File: rtl/uart_tx_byte.sv
// One 8N1 UART frame: start bit, 8 data bits LSB first, stop bit.
// Handshake: a one-cycle load starts a frame (tx falls on that edge);
// byte_in is sampled at the end of the start bit, so the caller may still
// be settling it while the start bit is on the line. frame_done marks the
// last cycle of the stop bit; a load may be issued on the following cycle.
module uart_tx_byte
   import debug_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1085
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] byte_in,
   output logic       tx,
   output logic       bit_tick,
   output logic [3:0] bit_idx,
   output logic       frame_done
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CW-1:0] baud_cnt;
   logic [7:0]    shift_q;
   logic          active;

   // bit_idx 0 is the start bit, 1..8 the data bits, 9 the stop bit.
   assign bit_tick   = active && (baud_cnt == CW'(CLKS_PER_BIT - 1));
   assign frame_done = bit_tick && (bit_idx == 4'd9);

   // Baud counter, bit counter and shift register for the current frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx       <= UART_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift_q  <= '0;
         active   <= 1'b0;
      end else if (load) begin
         active   <= 1'b1;
         baud_cnt <= '0;
         bit_idx  <= '0;
         tx       <= UART_START;
      end else if (active) begin
         if (bit_tick) begin
            baud_cnt <= '0;
            if (bit_idx == 4'd0) begin
               tx      <= byte_in[0];
               shift_q <= {1'b0, byte_in[7:1]};
               bit_idx <= 4'd1;
            end else if (bit_idx < 4'd8) begin
               tx      <= shift_q[0];
               shift_q <= {1'b0, shift_q[7:1]};
               bit_idx <= bit_idx + 4'd1;
            end else if (bit_idx == 4'd8) begin
               tx      <= UART_IDLE;
               bit_idx <= 4'd9;
            end else begin
               active  <= 1'b0;
               bit_idx <= '0;
            end
         end else begin
            baud_cnt <= baud_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/debug_mem_dump.sv
// Walks the data-memory debug port over every word and streams each word
// as four little-endian bytes on a UART line, without stalling the core.
module debug_mem_dump
   import debug_pkg::*;
#(
   parameter int DATA_ADDR_WIDTH = 8,
   parameter int CLKS_PER_BIT    = 1085
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   debug_mem_dump_if.master  mem,
   output logic              tx,
   output logic              busy,
   output logic              done,
   output state_t            dbg_state
);

   state_t                     state_q;
   logic [DATA_ADDR_WIDTH-1:0] addr_q;
   logic [31:0]                word_q;
   logic [1:0]                 byte_idx_q;

   logic       load;
   logic [7:0] byte_sel;
   logic       bit_tick;
   logic [3:0] bit_idx;
   logic       frame_done;
   logic       last_byte;

   assign last_byte       = (byte_idx_q == 2'(BYTES_PER_WORD - 1));
   // A frame starts from CAPTURE (first byte) or NEXT (following bytes).
   assign load            = (state_q == CAPTURE) || ((state_q == NEXT) && !last_byte);
   // Taken from the latched word, so core writes after CAPTURE cannot leak in.
   assign byte_sel        = word_byte(word_q, byte_idx_q);
   assign mem.debug_addr  = addr_q;
   assign dbg_state       = state_q;

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .byte_in    (byte_sel),
      .tx         (tx),
      .bit_tick   (bit_tick),
      .bit_idx    (bit_idx),
      .frame_done (frame_done)
   );

   // Address, word and byte sequencing; START/DATA/STOP track the frame phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         word_q     <= '0;
         byte_idx_q <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= FETCH;
                  busy    <= 1'b1;
               end
            end
            FETCH:   state_q <= CAPTURE;
            CAPTURE: begin
               word_q     <= mem.debug_data;
               byte_idx_q <= '0;
               state_q    <= START;
            end
            START: if (bit_tick) state_q <= DATA;
            DATA:  if (bit_tick && (bit_idx == 4'd8)) state_q <= STOP;
            STOP:  if (frame_done) state_q <= NEXT;
            NEXT: begin
               if (!last_byte) begin
                  byte_idx_q <= byte_idx_q + 2'd1;
                  state_q    <= START;
               end else if (&addr_q) begin
                  addr_q  <= '0;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  addr_q  <= addr_q + DATA_ADDR_WIDTH'(1);
                  state_q <= FETCH;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_mem_dump.sv
// Directed bench for debug_mem_dump: UART decoder on tx, done-pulse log,
// per-scenario tasks with hand-computed expectations.
module tb_debug_mem_dump;
   import debug_pkg::*;

   localparam int AW  = 2;
   localparam int CPB = 4;
   localparam int WORD_CYCLES = 4 * (10 * CPB + 1) + 2;  // 166

   // ---------------- clock / reset ----------------
   logic   clk = 1'b0;
   logic   rst = 1'b1;
   logic   start = 1'b0;
   logic   tx, busy, done;
   state_t dbg_state;
   int     cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   debug_mem_dump_if #(.ADDR_W(AW)) mem_if ();

   debug_mem_dump #(
      .DATA_ADDR_WIDTH (AW),
      .CLKS_PER_BIT    (CPB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mem       (mem_if),
      .tx        (tx),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   // Registered-read data memory model.
   logic [31:0] mem_arr [4];
   always @(posedge clk) mem_if.debug_data <= mem_arr[mem_if.debug_addr];

   // ---------------- scoreboard state ----------------
   int          vectors = 0;
   int          miscompares = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  rx_q[$];
   int          done_q[$];
   int          frame_err = 0;

   // UART 8N1 decoder sampling mid-bit on the falling clock edge.
   int         mon_off = 0;
   logic       mon_busy = 1'b0;
   logic [7:0] mon_byte = '0;
   always @(negedge clk) begin
      if (rst) begin
         mon_busy = 1'b0;
      end else begin
         if (done) done_q.push_back(cyc);
         if (!mon_busy) begin
            if (tx === 1'b0) begin
               mon_busy = 1'b1;
               mon_off  = 0;
            end
         end else begin
            mon_off++;
            if (mon_off == CPB / 2 && tx !== 1'b0) frame_err++;
            if (mon_off >= CPB + CPB / 2 && mon_off < 9 * CPB && ((mon_off - CPB / 2) % CPB) == 0)
               mon_byte[(mon_off - CPB / 2) / CPB - 1] = tx;
            if (mon_off == 9 * CPB + CPB / 2) begin
               if (tx !== 1'b1) frame_err++;
               rx_q.push_back(mon_byte);
               mon_busy = 1'b0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rx_q.delete();
      done_q.delete();
      exp_q.delete();
      frame_err = 0;
   endtask

   // Raises start for one cycle; k is the edge that samples it.
   task automatic pulse_start(output int k);
      start = 1'b1;
      k = cyc + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_bytes(input int n, input int budget, output bit ok);
      for (int i = 0; i < budget; i++) begin
         if (rx_q.size() >= n) break;
         @(negedge clk);
      end
      ok = (rx_q.size() >= n);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         vectors++;
         if ({tx, busy, done, mem_if.debug_addr} !== {1'b1, 1'b0, 1'b0, 2'b00} || dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL reset_idle cyc %0d: tx=%b busy=%b done=%b addr=%0d state=%0d expected tx=1 busy=0 done=0 addr=0 state=IDLE",
                     i, tx, busy, done, mem_if.debug_addr, dbg_state);
         end
      end
   endtask

   task automatic test_single_word();
      int k;
      bit ok;
      apply_reset();
      mem_arr[0] = 32'h12345678; mem_arr[1] = '0; mem_arr[2] = '0; mem_arr[3] = '0;
      exp_q = '{8'h78, 8'h56, 8'h34, 8'h12};
      pulse_start(k);
      vectors++;
      if (busy !== 1'b1 || tx !== 1'b1) begin
         miscompares++;
         $display("FAIL single_accept: busy=%b tx=%b expected busy=1 tx=1", busy, tx);
      end
      @(negedge clk);  // after edge k+1
      vectors++;
      if (tx !== 1'b1 || dbg_state !== CAPTURE) begin
         miscompares++;
         $display("FAIL single_pre_start: tx=%b state=%0d expected tx=1 state=CAPTURE", tx, dbg_state);
      end
      for (int i = 0; i < CPB; i++) begin
         @(negedge clk);  // after edges k+2 .. k+5
         vectors++;
         if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL single_start_bit +%0d: tx=%b expected 0", i + 2, tx);
         end
      end
      wait_bytes(4, 400, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL single_timeout: got %0d bytes expected 4", rx_q.size());
      end
      for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
         vectors++;
         if (rx_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL single_byte[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]);
         end
      end
      vectors++;
      if (frame_err != 0) begin
         miscompares++;
         $display("FAIL single_framing: got %0d errors expected 0", frame_err);
      end
      apply_reset();
   endtask

   task automatic load_full_mem();
      mem_arr[0] = 32'hA5A5A5A5; mem_arr[1] = 32'h00000001;
      mem_arr[2] = 32'hFFFFFFFF; mem_arr[3] = 32'h80000000;
   endtask

   task automatic test_full_dump();
      int k;
      bit seen;
      logic [31:0] w;
      apply_reset();
      load_full_mem();
      for (int a = 0; a < 4; a++) begin
         w = mem_arr[a];
         for (int b = 0; b < 4; b++) exp_q.push_back(w[b*8 +: 8]);
      end
      pulse_start(k);
      seen = 1'b0;
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      vectors++;
      if (!seen || cyc != k + 4 * WORD_CYCLES) begin
         miscompares++;
         $display("FAIL full_done_time: seen=%b at %0d expected %0d", seen, cyc - k, 4 * WORD_CYCLES);
      end
      vectors++;
      if (busy !== 1'b0 || dbg_state !== IDLE) begin
         miscompares++;
         $display("FAIL full_busy_at_done: busy=%b state=%0d expected busy=0 state=IDLE", busy, dbg_state);
      end
      repeat (10) @(negedge clk);
      vectors++;
      if (done_q.size() != 1) begin
         miscompares++;
         $display("FAIL full_done_count: got %0d expected 1", done_q.size());
      end
      vectors++;
      if (mem_if.debug_addr !== 2'd0) begin
         miscompares++;
         $display("FAIL full_addr_end: got %0d expected 0", mem_if.debug_addr);
      end
      vectors++;
      if (rx_q.size() != 16) begin
         miscompares++;
         $display("FAIL full_byte_count: got %0d expected 16", rx_q.size());
      end
      for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
         vectors++;
         if (rx_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL full_byte[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]);
         end
      end
      vectors++;
      if (frame_err != 0) begin
         miscompares++;
         $display("FAIL full_framing: got %0d errors expected 0", frame_err);
      end
   endtask

   task automatic test_start_held();
      int k;
      bit seen;
      apply_reset();
      load_full_mem();
      start = 1'b1;
      k = cyc + 1;
      seen = 1'b0;
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      vectors++;
      if (!seen || cyc != k + 4 * WORD_CYCLES || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL held_done: seen=%b at %0d busy=%b expected at %0d busy=0",
                  seen, cyc - k, busy, 4 * WORD_CYCLES);
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || dbg_state !== FETCH) begin
         miscompares++;
         $display("FAIL held_restart: busy=%b state=%0d expected busy=1 state=FETCH", busy, dbg_state);
      end
      vectors++;
      if (done_q.size() != 1 || rx_q.size() != 16) begin
         miscompares++;
         $display("FAIL held_single_dump: done=%0d bytes=%0d expected done=1 bytes=16", done_q.size(), rx_q.size());
      end
      start = 1'b0;
      apply_reset();
   endtask

   task automatic test_reset_mid();
      int k;
      bit ok;
      apply_reset();
      load_full_mem();
      pulse_start(k);
      // Word 1 start bit begins at k+168; its second data bit (0) spans k+176..k+179.
      while (cyc < k + WORD_CYCLES + 12) @(negedge clk);
      vectors++;
      if (dbg_state !== DATA || tx !== 1'b0 || mem_if.debug_addr !== 2'd1) begin
         miscompares++;
         $display("FAIL mid_precond: state=%0d tx=%b addr=%0d expected state=DATA tx=0 addr=1",
                  dbg_state, tx, mem_if.debug_addr);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_async: tx=%b busy=%b done=%b expected tx=1 busy=0 done=0", tx, busy, done);
      end
      @(negedge clk);
      rst = 1'b0;
      rx_q.delete();
      done_q.delete();
      frame_err = 0;
      repeat (60) @(negedge clk);
      vectors++;
      if (rx_q.size() != 0 || done_q.size() != 0 || tx !== 1'b1 || mem_if.debug_addr !== 2'd0) begin
         miscompares++;
         $display("FAIL mid_quiet: bytes=%0d dones=%0d tx=%b addr=%0d expected 0 0 1 0",
                  rx_q.size(), done_q.size(), tx, mem_if.debug_addr);
      end
      exp_q = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00};
      pulse_start(k);
      wait_bytes(8, 600, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL mid_timeout: got %0d bytes expected 8", rx_q.size());
      end
      for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
         vectors++;
         if (rx_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL mid_byte[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]);
         end
      end
      apply_reset();
   endtask

   task automatic test_word_latch();
      int k;
      bit ok;
      apply_reset();
      mem_arr[0] = 32'h11111111; mem_arr[1] = '0; mem_arr[2] = '0; mem_arr[3] = '0;
      exp_q = '{8'h11, 8'h11, 8'h11, 8'h11};
      pulse_start(k);
      while (cyc < k + 2) @(negedge clk);
      vectors++;
      if (dbg_state !== START) begin
         miscompares++;
         $display("FAIL latch_state: got %0d expected START", dbg_state);
      end
      mem_arr[0] = 32'h22222222;
      wait_bytes(4, 400, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL latch_timeout: got %0d bytes expected 4", rx_q.size());
      end
      for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
         vectors++;
         if (rx_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL latch_byte[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]);
         end
      end
      apply_reset();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      mem_arr[0] = '0; mem_arr[1] = '0; mem_arr[2] = '0; mem_arr[3] = '0;
      test_reset();
      test_single_word();
      test_full_dump();
      test_start_held();
      test_reset_mid();
      test_word_latch();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
